toggle_cover_drain: RTL and testbench

- Parametrised successor to the per-width toggle coverage reporters.
- Records the first occurrence of each toggle point in a sticky coverage map instead of calling a per-cycle DPI function for every active bit.
- Emits each newly covered point exactly once, as a global cover index, on a valid/ready stream to a downstream coverage collector/DPI bridge.
- Keeps a running count of covered points for formal/BMC cover targets. One instance sits beside each instrumented signal group.

---
 rtl/toggle_cover_drain_if.sv | 9 +
 rtl/toggle_cover_drain.sv | 94 +++++++++
 tb/tb_toggle_cover_drain.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/toggle_cover_drain_if.sv
// Cover-index stream from a toggle coverage drain to the downstream collector.
interface toggle_cover_drain_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;

  modport master (output out_valid, output out_index, input out_ready);
  modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/toggle_cover_drain.sv
// Sticky toggle coverage map: records first hit of each point, emits each newly
// covered point once as a global index on a valid/ready stream, and counts coverage.
module toggle_cover_drain #(
  parameter int              WIDTH       = 62,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 8940,
  parameter int              CNT_W       = $clog2(WIDTH+1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        valid,
  input  logic                    enable,
  input  logic                    clear,
  toggle_cover_drain_if.master    out,
  output logic [CNT_W-1:0]        covered_count,
  output logic                    all_covered
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (COVER_INDEX + longint'(WIDTH) > COVER_TOTAL) begin : g_range_chk
    $error("toggle_cover_drain: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] covered, pending, new_hits, pend_clr;
  logic [CNT_W-1:0] hit_cnt;
  logic [IDX_W-1:0] sel_bit;
  logic             sel_found, load;

  assign new_hits    = valid & ~covered & {WIDTH{enable}};
  assign load        = !out.out_valid || out.out_ready;
  assign all_covered = (covered_count == CNT_W'(WIDTH));

  // Lowest set bit of registered pending only; this cycle's hits wait one edge.
  always_comb begin
    sel_found = 1'b0;
    sel_bit   = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel_bit   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    if (load && sel_found) pend_clr[sel_bit] = 1'b1;
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < WIDTH; i++) hit_cnt = hit_cnt + CNT_W'(new_hits[i]);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      out.out_valid <= 1'b0;
      out.out_index <= '0;
    end else begin
      covered       <= covered | new_hits;
      pending       <= (pending & ~pend_clr) | new_hits;
      covered_count <= covered_count + hit_cnt;
      if (load) begin
        out.out_valid <= sel_found;
        if (sel_found) out.out_index <= 64'(COVER_INDEX) + 64'(sel_bit);
      end
    end
  end

`ifndef SYNTHESIS
  logic             stall_q;
  logic [63:0]      idx_q;
  logic [CNT_W-1:0] cov_pop;

  always_comb begin
    cov_pop = '0;
    for (int i = 0; i < WIDTH; i++) cov_pop = cov_pop + CNT_W'(covered[i]);
  end

  always_ff @(posedge clock) begin
    stall_q <= !reset && !clear && out.out_valid && !out.out_ready;
    idx_q   <= out.out_index;
    if (!reset) begin
      if (stall_q) assert (out.out_valid && out.out_index == idx_q)
        else $error("out_index changed while stalled");
      assert (covered_count == cov_pop) else $error("covered_count != popcount(covered)");
      assert ((pending & ~covered) == '0) else $error("pending not subset of covered");
    end
  end
`endif
endmodule

// File: tb/tb_toggle_cover_drain.sv
// Directed bench for toggle_cover_drain (WIDTH=62, COVER_INDEX=100).
module tb_toggle_cover_drain;
  localparam int W  = 62;
  localparam int CI = 100;
  localparam int CW = $clog2(W+1);

  logic          clock = 1'b0;
  logic          reset, enable, clear;
  logic [W-1:0]  valid;
  logic [CW-1:0] covered_count;
  logic          all_covered;
  int            total = 0, bad = 0;

  toggle_cover_drain_if bus();

  toggle_cover_drain #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(8940)) dut (
    .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
    .out(bus), .covered_count(covered_count), .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  function automatic logic [W-1:0] bit_of(input int b);
    logic [W-1:0] v;
    v = '0; v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    int n_emit;
    logic [63:0] last_idx;
    reset = 1'b1; enable = 1'b1; clear = 1'b0; valid = '0; bus.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_count", 64'(covered_count), 0);
    chk("rst_allcov", 64'(all_covered), 0);

    // single hit, 2-edge latency, one-cycle presentation
    valid = bit_of(5); tick(); valid = '0;
    chk("single_v_k", 64'(bus.out_valid), 0);
    chk("single_cnt", 64'(covered_count), 1);
    tick();
    chk("single_v_k1", 64'(bus.out_valid), 1);
    chk("single_idx", bus.out_index, 105);
    tick();
    chk("single_drop", 64'(bus.out_valid), 0);

    // simultaneous hits under backpressure
    do_clear();
    bus.out_ready = 1'b0;
    valid = bit_of(0) | bit_of(3) | bit_of(61); tick(); valid = '0;
    chk("multi_cnt", 64'(covered_count), 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("multi_hold_v", 64'(bus.out_valid), 1);
      chk("multi_hold_idx", bus.out_index, 100);
    end
    bus.out_ready = 1'b1;
    tick(); chk("multi_idx3", bus.out_index, 103);
    chk("multi_v3", 64'(bus.out_valid), 1);
    tick(); chk("multi_idx61", bus.out_index, 161);
    tick(); chk("multi_end", 64'(bus.out_valid), 0);

    // repeat hits of one point emit once
    do_clear();
    n_emit = 0; last_idx = '0;
    for (int i = 0; i < 20; i++) begin
      valid = (i < 10) ? bit_of(7) : '0;
      bus.out_ready = (i >= 6);
      if (bus.out_valid && bus.out_ready) begin n_emit++; last_idx = bus.out_index; end
      tick();
    end
    chk("rep_emits", 64'(n_emit), 1);
    chk("rep_idx", last_idx, 107);
    chk("rep_cnt", 64'(covered_count), 1);

    // full coverage, ascending drain
    do_clear();
    bus.out_ready = 1'b1;
    valid = '1; tick(); valid = '0;
    chk("full_cnt", 64'(covered_count), 62);
    chk("full_allcov", 64'(all_covered), 1);
    for (int i = 0; i < W; i++) begin
      tick();
      chk("full_v", 64'(bus.out_valid), 1);
      chk("full_idx", bus.out_index, 64'(CI + i));
    end
    tick();
    chk("full_drop", 64'(bus.out_valid), 0);

    // enable gating
    do_clear();
    enable = 1'b0; valid = bit_of(9); tick(); tick(); valid = '0;
    chk("en0_cnt", 64'(covered_count), 0);
    chk("en0_v", 64'(bus.out_valid), 0);
    enable = 1'b1; valid = bit_of(9); tick(); valid = '0; tick();
    chk("en1_v", 64'(bus.out_valid), 1);
    chk("en1_idx", bus.out_index, 109);
    chk("en1_cnt", 64'(covered_count), 1);

    // clear during an accepted handshake
    do_clear();
    bus.out_ready = 1'b1;
    valid = bit_of(1) | bit_of(2) | bit_of(4) | bit_of(6) | bit_of(8); tick(); valid = '0;
    tick();
    chk("clr_pre_idx", bus.out_index, 101);
    do_clear();
    chk("clr_v", 64'(bus.out_valid), 0);
    chk("clr_cnt", 64'(covered_count), 0);
    chk("clr_idx", bus.out_index, 0);
    tick();
    chk("clr_v2", 64'(bus.out_valid), 0);
    valid = bit_of(2); tick(); valid = '0; tick();
    chk("clr_rehit_idx", bus.out_index, 102);
    chk("clr_rehit_v", 64'(bus.out_valid), 1);
    chk("clr_rehit_cnt", 64'(covered_count), 1);

    // reset during activity
    do_clear();
    valid = bit_of(10) | bit_of(11); tick(); valid = '0; tick();
    chk("rst2_pre_idx", bus.out_index, 110);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_v", 64'(bus.out_valid), 0);
    chk("rst2_idx", bus.out_index, 0);
    chk("rst2_cnt", 64'(covered_count), 0);
    chk("rst2_allcov", 64'(all_covered), 0);
    tick();
    chk("rst2_v2", 64'(bus.out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
